// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;
endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low segment decoder; zero latency.
// Shared with the LED/debug paths, so it carries no state.
module hex_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with per-frame input snapshot.
// All outputs registered, one cycle behind the counter/snapshot state; no backpressure.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic [7:0]  dp_in,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_o
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_snap_val;
  logic [7:0]    r_snap_dp;
  logic          r_snap_lz;
  logic [7:0]    r_an;
  seg_t          r_seg;
  logic          r_dp;
  logic          r_frame;

  logic          w_tick;
  logic          w_gap;
  logic          w_lz_blank;
  logic [3:0]    w_nib;
  seg_t          w_dec;
  logic [7:0]    w_an_on;

  assign w_tick  = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_nib   = r_snap_val[{r_idx, 2'b00} +: 4];
  assign w_an_on = ~(8'b1 << r_idx);

  // A digit is a leading zero when it and everything to its left is zero.
  assign w_lz_blank = r_snap_lz && (r_idx != 3'd0) &&
                      ((r_snap_val >> {r_idx, 2'b00}) == 32'd0);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_gap
      assign w_gap = 1'b0;
    end else begin : g_gap
      assign w_gap = (32'(r_cnt) < 32'(BLANK_CYCLES));
    end
  endgenerate

  hex_to_seg u_hex_to_seg (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_snap_val <= 32'd0;
      r_snap_dp  <= 8'd0;
      r_snap_lz  <= 1'b0;
      r_an       <= AN_OFF;
      r_seg      <= SEG_BLANK;
      r_dp       <= 1'b1;
      r_frame    <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      // Sampling only at the frame boundary keeps every frame self-consistent.
      if (w_tick && (r_idx == 3'd7)) begin
        r_snap_val <= value_in;
        r_snap_dp  <= dp_in;
        r_snap_lz  <= blank_lz;
      end

      r_frame <= w_tick && (r_idx == 3'd7);
      r_an    <= w_gap ? AN_OFF : w_an_on;
      r_seg   <= w_lz_blank ? SEG_BLANK : w_dec;
      r_dp    <= ~r_snap_dp[r_idx];
    end
  end

  assign an      = r_an;
  assign seg     = r_seg;
  assign dp      = r_dp;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: two instances (4/1 and 2/0 timing) share stimulus,
// a cycle-indexed reference model predicts every output cycle.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value_in;
  logic [7:0]  dp_in;
  logic        blank_lz;

  logic [7:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fr_a, fr_b;

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame_o(fr_a)
  );

  seg7_scan #(.REFRESH_DIV(2), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_o(fr_b)
  );

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [16:0] a;
    logic [16:0] b;
  } exp_t;

  exp_t        exp_q [$];
  logic [40:0] hist  [$];   // {lz, dp, value} present during each post-reset cycle
  int          s       = 0; // cycles since the last reset edge
  bit          started = 0;
  int          tests   = 0;
  int          fails   = 0;
  int          frames_exp = 0;
  int          frames_got = 0;

  // Snapshot in force while the state of cycle s-1 is displayed.
  function automatic logic [40:0] snap_of(int sc, int rd);
    int f;
    if (sc == 0) return '0;
    f = (sc - 1) / (8 * rd);
    if (f == 0) return '0;
    return hist[f * 8 * rd - 1];
  endfunction

  // Expected {an, seg, dp, frame} in output cycle sc.
  function automatic logic [16:0] model_out(int sc, int rd, int bl, logic [40:0] snap);
    logic [31:0] v;
    logic [7:0]  d;
    logic        lz;
    logic [3:0]  nib;
    logic [6:0]  sg;
    logic [7:0]  a;
    logic        fr;
    int p, idx, cnt, msd;
    if (sc == 0) return {8'hFF, 7'h7F, 1'b1, 1'b0};
    {lz, d, v} = snap;
    p   = sc - 1;
    idx = (p / rd) % 8;
    cnt = p % rd;
    msd = 0;
    for (int k = 0; k < 8; k++)
      if (v[4*k +: 4] != 4'h0) msd = k;
    nib = v[4*idx +: 4];
    sg  = (lz && idx > msd) ? 7'h7F : seg_tbl[nib];
    a   = (cnt < bl) ? 8'hFF : ~(8'h01 << idx);
    fr  = ((sc % (8 * rd)) == 0);
    return {a, sg, ~d[idx], fr};
  endfunction

  // Model: tracks time since reset and queues the expected outputs per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        hist.delete();
        s       = 0;
        started = 1;
      end else if (started) begin
        hist.push_back({blank_lz, dp_in, value_in});
        s++;
      end
      if (started) begin
        e.a = model_out(s, 4, 1, snap_of(s, 4));
        e.b = model_out(s, 2, 0, snap_of(s, 2));
        frames_exp += int'(e.a[0]);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: pops one expectation per output cycle and compares both instances.
  initial begin
    exp_t        e;
    logic [16:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {an_a, seg_a, dp_a, fr_a};
        frames_got += int'(fr_a);
        tests++;
        if (got !== e.a) begin
          fails++;
          $display("FAIL scan_a cyc=%0d: got an=%h seg=%b dp=%b fr=%b, want an=%h seg=%b dp=%b fr=%b",
                   s, got[16:9], got[8:2], got[1], got[0], e.a[16:9], e.a[8:2], e.a[1], e.a[0]);
        end
        got = {an_b, seg_b, dp_b, fr_b};
        tests++;
        if (got !== e.b) begin
          fails++;
          $display("FAIL scan_b cyc=%0d: got an=%h seg=%b dp=%b fr=%b, want an=%h seg=%b dp=%b fr=%b",
                   s, got[16:9], got[8:2], got[1], got[0], e.b[16:9], e.b[8:2], e.b[1], e.b[0]);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] v, input logic [7:0] d, input logic lz, input int n);
    value_in = v;
    dp_in    = d;
    blank_lz = lz;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int          waited;
    logic [31:0] rv;
    rst = 1'b1;
    value_in = 32'd0;
    dp_in    = 8'd0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    drive(32'h0000_0000, 8'h00, 1'b0, 70);
    drive(32'h1234_5678, 8'h01, 1'b0, 80);
    drive(32'h0000_00A5, 8'h00, 1'b1, 80);
    drive(32'h1111_1111, 8'h00, 1'b0, 45);
    drive(32'h2222_2222, 8'h00, 1'b0, 80);

    // Reset pulse while dut_a is on digit 5.
    waited = 0;
    while (((s / 4) % 8) != 5 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (waited >= 200) begin
      fails++;
      $display("FAIL digit5_wait: waited %0d cycles, required < 200", waited);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(32'h2222_2222, 8'h00, 1'b0, 70);

    for (int it = 0; it < 40; it++) begin
      rv = $urandom;
      rv = rv >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rv = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      drive(rv, 8'($urandom), 1'($urandom), int'($urandom_range(1, 40)));
    end

    repeat (2) @(negedge clk);
    tests++;
    if (frames_got != frames_exp) begin
      fails++;
      $display("FAIL frame_count: got %0d pulses, want %0d", frames_got, frames_exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
